// File: rtl/qam_pkg.sv
// qam_pkg: shared 16-QAM demapper types and constants, also used by the Viterbi decoder
package qam_pkg;
    typedef enum logic [1:0] {
        PRIME,
        EMIT_I,
        EMIT_Q
    } state_t;
    localparam logic [1:0] OUTER_NEG = 2'b00;
    localparam logic [1:0] INNER_NEG = 2'b01;
    localparam logic [1:0] INNER_POS = 2'b11;
    localparam logic [1:0] OUTER_POS = 2'b10;
    localparam int FRAME_LEN = 31;
endpackage

// File: rtl/inv_qam16_demap_if.sv
// inv_qam16_demap_if: symbol input handshake and dibit output bundle of the demapper
interface inv_qam16_demap_if #(
    parameter int SAMPLE_W = 8
);
    logic                       sym_valid;
    logic                       sym_ready;
    logic signed [SAMPLE_W-1:0] sym_i;
    logic signed [SAMPLE_W-1:0] sym_q;
    logic [1:0]                 inv_QAM_out;
    logic                       out_valid;
    logic                       frame_start;
    logic [7:0]                 underflow_cnt;
    modport master (
        output sym_valid, sym_i, sym_q,
        input  sym_ready, inv_QAM_out, out_valid, frame_start, underflow_cnt
    );
    modport slave (
        input  sym_valid, sym_i, sym_q,
        output sym_ready, inv_QAM_out, out_valid, frame_start, underflow_cnt
    );
endinterface

// File: rtl/sym_fifo.sv
// sym_fifo: DEPTH x 4-bit synchronous FIFO holding sliced symbols, with registered full flag
module sym_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [3:0]  i_data,
    output logic [3:0]  o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count
);
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic [AW:0]   w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    assign o_head    = r_mem[r_rp];
    assign o_full    = r_full;
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;

    // storage array; stale entries after flush are unreachable because the pointers reset
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wp] <= i_data;
    end

    // pointers, occupancy and full flag; flush wins over push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_wp   <= i_push ? r_wp + 1'b1 : r_wp;
            r_rp   <= i_pop ? r_rp + 1'b1 : r_rp;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == (AW+1)'(DEPTH));
        end
    end
endmodule

// File: rtl/inv_qam16_demap.sv
// inv_qam16_demap: hard-decision 16-QAM slicer feeding a framed dibit stream to the Viterbi decoder
module inv_qam16_demap #(
    parameter int SAMPLE_W  = 8,
    parameter int THRESH    = 64,
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 2,
    parameter int FRAME_LEN = qam_pkg::FRAME_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    inv_qam16_demap_if.slave bus
);
    import qam_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FRAME_LEN);

    // Gray slice of one axis; magnitude is one bit wider so the most negative sample is exact
    function automatic logic [1:0] slice(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W:0] w_mag;
        logic              w_inner;
        w_mag   = x[SAMPLE_W-1] ? -{x[SAMPLE_W-1], x} : {x[SAMPLE_W-1], x};
        w_inner = (w_mag < (SAMPLE_W+1)'(THRESH));
        return x[SAMPLE_W-1] ? (w_inner ? INNER_NEG : OUTER_NEG) : (w_inner ? INNER_POS : OUTER_POS);
    endfunction

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [3:0]    w_head;
    logic [AW:0]   w_count;
    state_t        r_state;
    state_t        w_next;
    logic [1:0]    w_dibit;
    logic          w_valid;
    logic          w_underflow;
    logic [1:0]    r_dibit;
    logic          r_valid;
    logic          r_frame_start;
    logic [FW-1:0] r_frame_cnt;
    logic [7:0]    r_underflow_cnt;

    assign w_push            = bus.sym_valid & ~w_full;
    assign bus.sym_ready     = ~w_full;
    assign bus.inv_QAM_out   = r_dibit;
    assign bus.out_valid     = r_valid;
    assign bus.frame_start   = r_frame_start;
    assign bus.underflow_cnt = r_underflow_cnt;

    sym_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({slice(bus.sym_i), slice(bus.sym_q)}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush)
            r_state <= PRIME;
        else
            r_state <= w_next;
    end

    // next state: prime once, then alternate I/Q; an empty FIFO holds in EMIT_I without re-priming
    always_comb begin
        w_next = r_state;
        case (r_state)
            PRIME:   w_next = (w_count >= (AW+1)'(PRIME_LVL)) ? EMIT_I : PRIME;
            EMIT_I:  w_next = w_empty ? EMIT_I : EMIT_Q;
            EMIT_Q:  w_next = EMIT_I;
            default: w_next = PRIME;
        endcase
    end

    // output decode; the head is popped only after its Q dibit, so EMIT_Q always has data
    always_comb begin
        w_dibit     = 2'b00;
        w_valid     = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        case (r_state)
            EMIT_I: begin
                w_valid     = ~w_empty;
                w_dibit     = w_empty ? 2'b00 : w_head[3:2];
                w_underflow = w_empty;
            end
            EMIT_Q: begin
                w_valid = 1'b1;
                w_dibit = w_head[1:0];
                w_pop   = 1'b1;
            end
            default: ;
        endcase
    end

    // registered outputs, frame counter advancing on valid dibits, saturating underflow count
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_dibit         <= 2'b00;
            r_valid         <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_cnt     <= '0;
            r_underflow_cnt <= 8'd0;
        end else begin
            r_dibit         <= w_dibit;
            r_valid         <= w_valid;
            r_frame_start   <= w_valid && (r_frame_cnt == '0);
            r_frame_cnt     <= !w_valid ? r_frame_cnt : (r_frame_cnt == FW'(FRAME_LEN-1)) ? '0 : r_frame_cnt + 1'b1;
            r_underflow_cnt <= (w_underflow && r_underflow_cnt != 8'hFF) ? r_underflow_cnt + 1'b1 : r_underflow_cnt;
        end
    end
endmodule

// File: tb/tb_inv_qam16_demap.sv
// tb_inv_qam16_demap: vector table, hand sequences and randomized stream checked against a queue model
module tb_inv_qam16_demap;
    import qam_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    inv_qam16_demap_if #(.SAMPLE_W(8)) bus ();
    inv_qam16_demap_if #(.SAMPLE_W(8)) bus2 ();

    inv_qam16_demap #(.PRIME_LVL(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    inv_qam16_demap #(.PRIME_LVL(8)) u_full (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus2.slave)
    );

    typedef struct {
        int         i;
        int         q;
        logic [1:0] ei;
        logic [1:0] eq;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cap[$];
    bit         capfs[$];
    logic [1:0] cap2[$];
    int         vcnt = 0;
    int         nfs = 0;
    bit         last_i = 1'b0;

    // reference slicer straight from the decision rules
    function automatic logic [1:0] ref_dibit(int x);
        logic [1:0] d;
        d[1] = (x >= 0);
        d[0] = ((x < 0 ? -x : x) < 64);
        return d;
    endfunction

    function automatic int lvl(logic [1:0] c);
        case (c)
            2'b00:   return -100;
            2'b01:   return -20;
            2'b11:   return 20;
            default: return 100;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        vcnt   = 0;
        last_i = 1'b0;
    endtask

    task automatic monitor();
        if (bus.out_valid) begin
            cap.push_back(bus.inv_QAM_out);
            capfs.push_back(bus.frame_start);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_dibit: got %0d expected none at %0t", bus.inv_QAM_out, $time);
            end else begin
                chk("dibit", bus.inv_QAM_out, exp_q.pop_front());
            end
            chk("frame_start", bus.frame_start, int'(vcnt % 31 == 0));
            nfs += bus.frame_start;
            last_i = (vcnt % 2 == 0);
            vcnt++;
        end else begin
            if (last_i)
                chk("q_follows_i", bus.out_valid, 1);
            chk("idle_zero", {bus.inv_QAM_out, bus.frame_start}, 0);
            last_i = 1'b0;
        end
    endtask

    task automatic tick();
        bit acc;
        bit fl;
        int si;
        int sq;
        acc = bus.sym_valid && bus.sym_ready && !flush && !reset;
        fl  = flush;
        si  = int'(bus.sym_i);
        sq  = int'(bus.sym_q);
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else if (acc) begin
            exp_q.push_back(ref_dibit(si));
            exp_q.push_back(ref_dibit(sq));
        end
        monitor();
    endtask

    task automatic push_sym(int i, int q);
        int n = 0;
        bit acc;
        bus.sym_valid = 1'b1;
        bus.sym_i     = 8'(i);
        bus.sym_q     = 8'(q);
        do begin
            acc = bus.sym_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        bus.sym_valid = 1'b0;
    endtask

    task automatic wait_valid(int maxc, output int n);
        n = 0;
        while (!bus.out_valid && n < maxc) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within %0d cycles", maxc);
        end
    endtask

    // capture the PRIME_LVL=8 instance's dibit stream
    always @(posedge clk) begin
        #1;
        if (bus2.out_valid)
            cap2.push_back(bus2.inv_QAM_out);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[10];
        int         n;
        int         idx;
        logic [3:0] c;
        int         exp2[$];
        tbl[0] = '{96, -96, 2'b10, 2'b00};
        tbl[1] = '{10, -10, 2'b11, 2'b01};
        tbl[2] = '{64, 0, 2'b10, 2'b11};
        tbl[3] = '{0, 0, 2'b11, 2'b11};
        tbl[4] = '{-64, 0, 2'b00, 2'b11};
        tbl[5] = '{-1, 0, 2'b01, 2'b11};
        tbl[6] = '{-128, 0, 2'b00, 2'b11};
        tbl[7] = '{63, -63, 2'b11, 2'b01};
        tbl[8] = '{127, -65, 2'b10, 2'b00};
        tbl[9] = '{-127, 65, 2'b00, 2'b10};
        bus.sym_valid  = 1'b0;
        bus.sym_i      = '0;
        bus.sym_q      = '0;
        bus2.sym_valid = 1'b0;
        bus2.sym_i     = '0;
        bus2.sym_q     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dibit", bus.inv_QAM_out, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_underflow", bus.underflow_cnt, 0);
        chk("rst_ready", bus.sym_ready, 1);
        reset = 1'b0;

        // full FIFO on the PRIME_LVL=8 instance: symbols 8..10 are refused, 11 is taken
        for (int k = 0; k < 12; k++) begin
            c = 4'(k);
            bus2.sym_valid = 1'b1;
            bus2.sym_i     = 8'(lvl(c[3:2]));
            bus2.sym_q     = 8'(lvl(c[1:0]));
            @(posedge clk);
            #1;
            if (k == 7) chk("full_ready_low", bus2.sym_ready, 0);
            if (k == 8) chk("full_ready_low2", bus2.sym_ready, 0);
            if (k == 9) begin
                chk("full_ready_low3", bus2.sym_ready, 0);
                chk("full_out_started", bus2.out_valid, 1);
            end
            if (k == 10) chk("ready_after_pop", bus2.sym_ready, 1);
        end
        bus2.sym_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) exp2.push_back(k);
        exp2.push_back(11);
        chk("full_stream_len", cap2.size(), 18);
        for (int s = 0; s < 9 && 2 * s + 1 < cap2.size(); s++) begin
            c = 4'(exp2[s]);
            chk("full_stream_i", cap2[2*s], ref_dibit(lvl(c[3:2])));
            chk("full_stream_q", cap2[2*s+1], ref_dibit(lvl(c[1:0])));
        end

        // table vectors: maps and thresholds
        model_clear();
        cap.delete();
        capfs.delete();
        for (int v = 0; v < 10; v++) push_sym(tbl[v].i, tbl[v].q);
        repeat (30) tick();
        chk("tbl_len", cap.size(), 20);
        for (int v = 0; v < 10 && 2 * v + 1 < cap.size(); v++) begin
            chk("tbl_i", cap[2*v], tbl[v].ei);
            chk("tbl_q", cap[2*v+1], tbl[v].eq);
        end
        if (capfs.size() > 0) chk("tbl_first_fs", capfs[0], 1);

        // asynchronous reset mid-stream clears outputs without waiting for a clock
        push_sym(50, 50);
        push_sym(-50, -50);
        push_sym(100, 100);
        wait_valid(10, n);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_dibit", bus.inv_QAM_out, 0);
        chk("arst_frame_start", bus.frame_start, 0);
        chk("arst_underflow", bus.underflow_cnt, 0);
        chk("arst_ready", bus.sym_ready, 1);
        tick();
        reset = 1'b0;
        push_sym(30, 30);
        for (int k = 0; k < 6; k++) begin
            chk("prime_hold", bus.out_valid, 0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // underflow: two symbols then silence
        push_sym(90, -90);
        push_sym(-30, 30);
        wait_valid(10, n);
        chk("prime2_latency", n, 2);
        for (int k = 0; k < 4; k++) begin
            chk("uf_valid_run", bus.out_valid, 1);
            if (k < 3) tick();
        end
        tick();
        chk("uf_out_valid", bus.out_valid, 0);
        chk("uf_dibit", bus.inv_QAM_out, 0);
        chk("uf_cnt1", bus.underflow_cnt, 1);
        tick();
        chk("uf_cnt2", bus.underflow_cnt, 2);
        repeat (260) tick();
        chk("uf_saturate", bus.underflow_cnt, 255);
        push_sym(-100, 20);
        tick();
        chk("resume_valid", bus.out_valid, 1);
        chk("resume_i_dibit", bus.inv_QAM_out, ref_dibit(-100));
        chk("resume_uf_hold", bus.underflow_cnt, 255);
        repeat (4) tick();

        // framing across gaps
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_uf_clear", bus.underflow_cnt, 0);
        nfs = 0;
        for (int s = 0; s < 40; s++) begin
            push_sym($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (40) tick();
        chk("frame_count", nfs, 3);
        chk("frame_dibits", vcnt, 80);
        chk("frame_drained", exp_q.size(), 0);

        // flush mid-frame with a competing push
        for (int s = 0; s < 6; s++) push_sym(70, -70);
        wait_valid(10, n);
        repeat (3) tick();
        flush = 1'b1;
        bus.sym_valid = 1'b1;
        bus.sym_i = 8'(5);
        bus.sym_q = 8'(5);
        tick();
        flush = 1'b0;
        bus.sym_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_ready", bus.sym_ready, 1);
        chk("flush_uf", bus.underflow_cnt, 0);
        push_sym(-20, 100);
        for (int k = 0; k < 5; k++) begin
            chk("flush_reprime", bus.out_valid, 0);
            tick();
        end
        push_sym(20, -100);
        wait_valid(10, n);
        chk("flush_frame_start", bus.frame_start, 1);
        chk("flush_first_dibit", bus.inv_QAM_out, ref_dibit(-20));
        repeat (10) tick();

        // randomized stream against the queue model
        for (int k = 0; k < 600; k++) begin
            bus.sym_valid = ($urandom_range(0, 3) != 0);
            bus.sym_i     = 8'($urandom_range(0, 255));
            bus.sym_q     = 8'($urandom_range(0, 255));
            tick();
        end
        bus.sym_valid = 1'b0;
        repeat (30) tick();
        chk("random_drained", exp_q.size(), 0);
        idx = vcnt;
        chk("random_even_dibits", idx % 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
